// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control unit
//
// Optional feature macro: CPU_SEQ_PERF_EN (builds the performance counters).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   opcode                     decoder opcode: 0=LOAD, 1=STORE, 2..7=ALU
//   change_pc, branch_addr     branch-taken flag and target, used in EXEC
//   imem_ack, dmem_ack         memory handshake completions
//   halt                       level request to stop at the next retire
//   pc, state                  fetch address and current FSM state
//   imem_req, ir_load, dec_load, alu_en, dmem_req, dmem_we, reg_we
//                              one-cycle datapath strobes
//   instr_done, halted         retire pulse, halt status
//   cycle_cnt, retire_cnt, stall_cnt  performance counters
module cpu_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      opcode,
  input  logic            change_pc,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            imem_req,
  output logic            ir_load,
  output logic            dec_load,
  output logic            alu_en,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            reg_we,
  output logic            instr_done,
  output logic            halted,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     retire_cnt,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dec_load   = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE: begin
        dec_load = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_en = (opcode >= 3'd2);
        // A taken branch retires here; no memory or writeback phase.
        if (change_pc) begin
          pc_d       = branch_addr;
          instr_done = 1'b1;
        end else if (opcode < 3'd2) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == 3'd1);
        if (dmem_ack) begin
          if (opcode == 3'd1) instr_done = 1'b1;
          else                state_d    = S_WB;
        end else begin
          stall = 1'b1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // halt only takes effect at an instruction boundary.
    if (instr_done) state_d = halt ? S_HALT : S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc    = pc_q;
  assign state = state_q;

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    retire_d = retire_q + {31'd0, instr_done};
    stall_d  = stall_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;
`else
  assign cycle_cnt  = 32'd0;
  assign retire_cnt = 32'd0;
  assign stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  opcode;
  logic        change_pc;
  logic [15:0] branch_addr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        halt;

  logic [15:0] pc;
  logic [2:0]  state;
  logic        imem_req, ir_load, dec_load, alu_en, dmem_req, dmem_we, reg_we;
  logic        instr_done, halted;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;

  logic [15:0] w_pc;
  logic [2:0]  w_state;
  logic        w_imem_req, w_ir_load, w_dec_load, w_alu_en, w_dmem_req, w_dmem_we, w_reg_we;
  logic        w_instr_done, w_halted;
  logic [31:0] w_cycle_cnt, w_retire_cnt, w_stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .change_pc(change_pc),
    .branch_addr(branch_addr), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt(halt),
    .pc(pc), .state(state), .imem_req(imem_req), .ir_load(ir_load), .dec_load(dec_load),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
    .instr_done(instr_done), .halted(halted), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .change_pc(change_pc),
    .branch_addr(branch_addr), .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt(halt),
    .pc(w_pc), .state(w_state), .imem_req(w_imem_req), .ir_load(w_ir_load),
    .dec_load(w_dec_load), .alu_en(w_alu_en), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .reg_we(w_reg_we), .instr_done(w_instr_done), .halted(w_halted),
    .cycle_cnt(w_cycle_cnt), .retire_cnt(w_retire_cnt), .stall_cnt(w_stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; opcode = 3'd0; change_pc = 1'b0; branch_addr = 16'h0;
    imem_ack = 1'b0; dmem_ack = 1'b0; halt = 1'b0;
    cyc();
    cyc();
  endtask

  // Memory responder: acks after iw/dw wait cycles; optionally raises halt in MEM.
  task automatic run_instr(input logic [2:0] op, input int iw, input int dw,
                           input logic br, input logic [15:0] ba, input bit hreq,
                           output int ncyc, output int nwe, output int nst,
                           output int nreq, output logic [2:0] done_state, output bit done);
    int fw = 0;
    int mw = 0;
    ncyc = 0; nwe = 0; nst = 0; nreq = 0; done_state = 3'd7; done = 1'b0;
    rst_n = 1'b1;
    opcode = op;
    for (int i = 0; i < 60 && !done; i++) begin
      imem_ack    = (state == 3'd0) && (fw >= iw);
      dmem_ack    = (state == 3'd3) && (mw >= dw);
      change_pc   = br;
      branch_addr = ba;
      if (hreq && state == 3'd3) halt = 1'b1;
      #1;
      ncyc++;
      if (state == 3'd0) fw++;
      if (state == 3'd3) mw++;
      if (reg_we) nwe++;
      if (dmem_req && dmem_we) nst++;
      if (dmem_req) nreq++;
      if (instr_done) begin
        done = 1'b1;
        done_state = state;
      end
      cyc();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; change_pc = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0 || pc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: state=%0d pc=%h required state=0 pc=0000", state, pc);
    end
    checks++;
    if ({imem_req, ir_load, dec_load, alu_en, dmem_req, dmem_we, reg_we, instr_done, halted} !== 9'b1_0000_0000) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 100000000",
               {imem_req, ir_load, dec_load, alu_en, dmem_req, dmem_we, reg_we, instr_done, halted});
    end
    checks++;
    if (cycle_cnt !== 32'd0 || retire_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: %0d %0d %0d required 0 0 0", cycle_cnt, retire_cnt, stall_cnt);
    end
    checks++;
    if (w_pc !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_pc_param: got %h required ffff", w_pc);
    end
  endtask

  task automatic test_alu();
    logic [2:0] seq [5];
    logic [2:0] exp_seq [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    bit seq_ok = 1'b1;
    do_reset();
    rst_n = 1'b1; opcode = 3'd3; imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      seq[i] = state;
      if (i == 2) begin
        checks++;
        if (alu_en !== 1'b1 || reg_we !== 1'b0) begin
          failures++;
          $display("FAIL alu_exec: alu_en=%b reg_we=%b required 1 0", alu_en, reg_we);
        end
      end
      if (i == 3) begin
        checks++;
        if (reg_we !== 1'b1 || instr_done !== 1'b1) begin
          failures++;
          $display("FAIL alu_wb: reg_we=%b instr_done=%b required 1 1", reg_we, instr_done);
        end
      end
      cyc();
    end
    for (int i = 0; i < 5; i++) if (seq[i] !== exp_seq[i]) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      failures++;
      $display("FAIL alu_sequence: got %0d %0d %0d %0d %0d required 0 1 2 4 0",
               seq[0], seq[1], seq[2], seq[3], seq[4]);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    // After the second FETCH edge pc has advanced twice (ack held through FETCH of next instr).
    checks++;
    if (state !== 3'd1 || pc !== 16'h0002) begin
      failures++;
      $display("FAIL alu_pc: state=%0d pc=%h required state=1 pc=0002", state, pc);
    end
    checks++;
    if (w_state !== 3'd1 || w_pc !== 16'h0001) begin
      failures++;
      $display("FAIL pc_wrap: state=%0d pc=%h required state=1 pc=0001", w_state, w_pc);
    end
  endtask

  task automatic test_pc_wrap();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd2, 0, 0, 1'b0, 16'h0, 1'b0, nc, nw, ns, nr, ds, dn);
    checks++;
    if (w_pc !== 16'h0000 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL pc_wrap_one: wrap_pc=%h pc=%h required 0000 0001", w_pc, pc);
    end
    checks++;
    if ({w_imem_req, w_ir_load, w_dec_load, w_alu_en, w_dmem_req, w_dmem_we, w_reg_we,
         w_instr_done, w_halted, w_state} !== 12'b1_0000_0000_000 ||
        w_retire_cnt !== retire_cnt || w_cycle_cnt !== cycle_cnt || w_stall_cnt !== stall_cnt) begin
      failures++;
      $display("FAIL wrap_outputs: state=%0d imem_req=%b required state=0 imem_req=1 others 0",
               w_state, w_imem_req);
    end
  endtask

  task automatic test_load();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd0, 2, 3, 1'b0, 16'h0, 1'b0, nc, nw, ns, nr, ds, dn);
    checks++;
    if (!dn || nc !== 10) begin
      failures++;
      $display("FAIL load_cycles: done=%0d cycles=%0d required done=1 cycles=10", dn, nc);
    end
    checks++;
    if (nw !== 1 || ns !== 0 || nr !== 4 || ds !== 3'd4) begin
      failures++;
      $display("FAIL load_strobes: reg_we=%0d stores=%0d dmem_req=%0d done_state=%0d required 1 0 4 4",
               nw, ns, nr, ds);
    end
`ifdef CPU_SEQ_PERF_EN
    checks++;
    if (stall_cnt !== 32'd5 || retire_cnt !== 32'd1 || cycle_cnt !== 32'd10) begin
      failures++;
      $display("FAIL load_counters: stall=%0d retire=%0d cycle=%0d required 5 1 10",
               stall_cnt, retire_cnt, cycle_cnt);
    end
`else
    checks++;
    if (stall_cnt !== 32'd0 || retire_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL load_counters_off: stall=%0d retire=%0d cycle=%0d required 0 0 0",
               stall_cnt, retire_cnt, cycle_cnt);
    end
`endif
  endtask

  task automatic test_store();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd1, 0, 0, 1'b0, 16'h0, 1'b0, nc, nw, ns, nr, ds, dn);
    checks++;
    if (!dn || nc !== 4 || nw !== 0 || ns !== 1 || ds !== 3'd3) begin
      failures++;
      $display("FAIL store: done=%0d cycles=%0d reg_we=%0d stores=%0d done_state=%0d required 1 4 0 1 3",
               dn, nc, nw, ns, ds);
    end
  endtask

  task automatic test_branch();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd5, 0, 0, 1'b1, 16'h00A0, 1'b0, nc, nw, ns, nr, ds, dn);
    checks++;
    if (!dn || nc !== 3 || nw !== 0 || ds !== 3'd2) begin
      failures++;
      $display("FAIL branch: done=%0d cycles=%0d reg_we=%0d done_state=%0d required 1 3 0 2",
               dn, nc, nw, ds);
    end
    checks++;
    if (state !== 3'd0 || pc !== 16'h00A0) begin
      failures++;
      $display("FAIL branch_pc: state=%0d pc=%h required state=0 pc=00a0", state, pc);
    end
  endtask

  task automatic test_back_to_back();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd4, 0, 0, 1'b0, 16'h0, 1'b0, nc, nw, ns, nr, ds, dn);
    run_instr(3'd6, 0, 0, 1'b0, 16'h0, 1'b0, nc, nw, ns, nr, ds, dn);
    checks++;
    if (!dn || nc !== 4 || pc !== 16'h0002 || state !== 3'd0) begin
      failures++;
      $display("FAIL back_to_back: cycles=%0d pc=%h state=%0d required 4 0002 0", nc, pc, state);
    end
`ifdef CPU_SEQ_PERF_EN
    checks++;
    if (retire_cnt !== 32'd2 || cycle_cnt !== 32'd8 || stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL b2b_counters: retire=%0d cycle=%0d stall=%0d required 2 8 0",
               retire_cnt, cycle_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_halt();
    int nc, nw, ns, nr;
    logic [2:0] ds;
    bit dn;
    do_reset();
    run_instr(3'd1, 0, 2, 1'b0, 16'h0, 1'b1, nc, nw, ns, nr, ds, dn);
    checks++;
    if (!dn || nc !== 6 || state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL halt_enter: done=%0d cycles=%0d state=%0d halted=%b imem_req=%b required 1 6 5 1 0",
               dn, nc, state, halted, imem_req);
    end
    cyc();
    checks++;
    if (state !== 3'd5 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL halt_hold: state=%0d pc=%h required 5 0001", state, pc);
    end
    halt = 1'b0;
    cyc();
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL halt_resume: state=%0d halted=%b imem_req=%b required 0 0 1", state, halted, imem_req);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    rst_n = 1'b1; opcode = 3'd1; imem_ack = 1'b1;
    cyc(); cyc(); cyc();
    imem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd3 || dmem_req !== 1'b1 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL mid_mem_setup: state=%0d dmem_req=%b pc=%h required 3 1 0001", state, dmem_req, pc);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if (state !== 3'd0 || pc !== 16'h0000 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mem: state=%0d pc=%h dmem_req=%b required 0 0000 0", state, pc, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_pc_wrap();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
